// File: rtl/pong_input_ctrl.sv
// Pong input conditioning: bat moves, human detect, start/pause/reset.
// PONG_INPUT_ACCEL_EN enables hold-time acceleration of bat moves.
module pong_input_ctrl (
  input  logic       glb_clk,
  input  logic       reset_n,
  input  logic       vsync,
  input  logic       l_up,
  input  logic       l_dn,
  input  logic       r_up,
  input  logic       r_dn,
  input  logic       btn_start,
  output logic [8:0] lbat_move,
  output logic [8:0] rbat_move,
  output logic       lbat_human,
  output logic       rbat_human,
  output logic       pause,
  output logic       game_reset
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_DEB1,
    S_DEB2,
    S_HELD,
    S_WAIT
  } start_t;

  localparam logic [9:0] IDLE_LAST = 10'd749;
  localparam logic [9:0] IDLE_MAX  = 10'd750;
  localparam logic [6:0] LONG_LAST = 7'd99;

  logic [4:0]      sync1;
  logic [4:0]      sync2;
  logic            vs_d;
  logic            tick;
  logic            start_btn;
  logic [1:0]      up;
  logic [1:0]      dn;
  logic [1:0]      press;
  logic [1:0]      human;
  logic [1:0]      human_nx;
  logic [1:0][9:0] idle_cnt;
  logic [1:0][3:0] mag;
  logic [1:0][8:0] delta;
  logic [1:0][8:0] move;
  start_t          st;
  start_t          st_nx;
  logic [6:0]      hold_frames;
  logic [6:0]      hf_nx;
  logic            toggle;
  logic            fire;
  logic            pause_nx;
`ifdef PONG_INPUT_ACCEL_EN
  logic [1:0][3:0] run;
  logic [1:0][3:0] run_nx;
  logic [1:0]      last_up;
  logic [1:0]      last_dn;
`endif

  assign tick       = vs_d & ~vsync;
  assign start_btn  = sync2[4];
  assign lbat_move  = move[0];
  assign rbat_move  = move[1];
  assign lbat_human = human[0];
  assign rbat_human = human[1];

  // index 0 = left bat, 1 = right bat
  always_comb begin
    for (int b = 0; b < 2; b++) begin
      up[b]    = sync2[2*b] & ~sync2[2*b+1];
      dn[b]    = sync2[2*b+1] & ~sync2[2*b];
      press[b] = sync2[2*b] | sync2[2*b+1];
`ifdef PONG_INPUT_ACCEL_EN
      if ((up[b] & last_up[b]) | (dn[b] & last_dn[b]))
        run_nx[b] = (run[b] == 4'hF) ? 4'hF : run[b] + 4'd1;
      else
        run_nx[b] = '0;
      mag[b] = run_nx[b][3] ? 4'd8 :
               run_nx[b][2] ? 4'd4 : 4'd2;
`else
      mag[b] = 4'd3;
`endif
      if (up[b])
        delta[b] = {5'd0, mag[b]};
      else if (dn[b])
        delta[b] = -{5'd0, mag[b]};
      else
        delta[b] = '0;
      if (press[b])
        human_nx[b] = 1'b1;
      else if (idle_cnt[b] == IDLE_LAST)
        human_nx[b] = 1'b0;
      else
        human_nx[b] = human[b];
    end
  end

  // hold_frames counts pressed frames since the first press
  always_comb begin
    st_nx  = st;
    hf_nx  = hold_frames;
    toggle = 1'b0;
    fire   = 1'b0;
    unique case (st)
      S_IDLE: begin
        if (start_btn) begin
          st_nx = S_DEB1;
          hf_nx = 7'd1;
        end
      end
      S_DEB1, S_DEB2: begin
        if (start_btn) begin
          st_nx = (st == S_DEB1) ? S_DEB2 : S_HELD;
          hf_nx = hold_frames + 7'd1;
        end else begin
          st_nx = S_IDLE;
          hf_nx = '0;
        end
      end
      S_HELD: begin
        if (!start_btn) begin
          toggle = 1'b1;
          st_nx  = S_IDLE;
          hf_nx  = '0;
        end else if (hold_frames == LONG_LAST) begin
          fire  = 1'b1;
          st_nx = S_WAIT;
          hf_nx = '0;
        end else begin
          hf_nx = hold_frames + 7'd1;
        end
      end
      S_WAIT: begin
        if (!start_btn) st_nx = S_IDLE;
      end
      default: begin
        st_nx = S_IDLE;
        hf_nx = '0;
      end
    endcase
    if (human_nx == 2'b00)
      pause_nx = 1'b0;
    else if (fire)
      pause_nx = 1'b0;
    else if (toggle)
      pause_nx = ~pause;
    else
      pause_nx = pause;
  end

  always_ff @(posedge glb_clk) begin
    if (!reset_n) begin
      sync1       <= '0;
      sync2       <= '0;
      vs_d        <= 1'b1;
      st          <= S_IDLE;
      hold_frames <= '0;
      pause       <= 1'b0;
      game_reset  <= 1'b0;
      human       <= '0;
      move        <= '0;
      idle_cnt    <= '0;
`ifdef PONG_INPUT_ACCEL_EN
      run         <= '0;
      last_up     <= '0;
      last_dn     <= '0;
`endif
    end else begin
      sync1      <= {btn_start, r_dn, r_up, l_dn, l_up};
      sync2      <= sync1;
      vs_d       <= vsync;
      game_reset <= 1'b0;
      if (tick) begin
        st          <= st_nx;
        hold_frames <= hf_nx;
        pause       <= pause_nx;
        game_reset  <= fire;
        human       <= human_nx;
        for (int b = 0; b < 2; b++) begin
          move[b] <= human_nx[b] ? delta[b] : '0;
          if (press[b])
            idle_cnt[b] <= '0;
          else if (idle_cnt[b] != IDLE_MAX)
            idle_cnt[b] <= idle_cnt[b] + 10'd1;
        end
`ifdef PONG_INPUT_ACCEL_EN
        run     <= run_nx;
        last_up <= up;
        last_dn <= dn;
`endif
      end
    end
  end

endmodule

// File: tb/tb_pong_input_ctrl.sv
// Bench for pong_input_ctrl: directed vector table, corner sequences,
// and random frames checked against a frame-level reference model.
module tb_pong_input_ctrl;

  logic       glb_clk = 1'b0;
  logic       reset_n = 1'b0;
  logic       vsync = 1'b1;
  logic       l_up = 1'b0;
  logic       l_dn = 1'b0;
  logic       r_up = 1'b0;
  logic       r_dn = 1'b0;
  logic       btn_start = 1'b0;
  logic [8:0] lbat_move;
  logic [8:0] rbat_move;
  logic       lbat_human;
  logic       rbat_human;
  logic       pause;
  logic       game_reset;

  pong_input_ctrl dut (
    .glb_clk   (glb_clk),
    .reset_n   (reset_n),
    .vsync     (vsync),
    .l_up      (l_up),
    .l_dn      (l_dn),
    .r_up      (r_up),
    .r_dn      (r_dn),
    .btn_start (btn_start),
    .lbat_move (lbat_move),
    .rbat_move (rbat_move),
    .lbat_human(lbat_human),
    .rbat_human(rbat_human),
    .pause     (pause),
    .game_reset(game_reset)
  );

  always #5 glb_clk = ~glb_clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

`ifdef PONG_INPUT_ACCEL_EN
  localparam logic [8:0] P2 = 9'd2;
  localparam logic [8:0] P4 = 9'd4;
  localparam logic [8:0] P8 = 9'd8;
  localparam logic [8:0] N2 = 9'h1FE;
  localparam logic [8:0] N4 = 9'h1FC;
`else
  localparam logic [8:0] P2 = 9'd3;
  localparam logic [8:0] P4 = 9'd3;
  localparam logic [8:0] P8 = 9'd3;
  localparam logic [8:0] N2 = 9'h1FD;
  localparam logic [8:0] N4 = 9'h1FD;
`endif

  // button vector order: {btn_start, r_dn, r_up, l_dn, l_up}
  localparam logic [4:0] B_NONE = 5'b00000;
  localparam logic [4:0] B_LUP  = 5'b00001;
  localparam logic [4:0] B_LDN  = 5'b00010;
  localparam logic [4:0] B_RUP  = 5'b00100;
  localparam logic [4:0] B_RDN  = 5'b01000;
  localparam logic [4:0] B_ST   = 5'b10000;

  typedef struct {
    logic [4:0]  btn;
    logic [21:0] exp;
  } vec_t;

  vec_t tbl[$];

  int n_chk = 0;
  int n_pass = 0;

  // reference model state, frame granularity
  int         m_run[2];
  int         m_dir[2];
  int         m_idle[2];
  bit         m_h[2];
  logic [8:0] m_mv[2];
  int         m_sp;
  bit         m_p;
  bit         m_gr;

  logic [21:0] o_out;

  task automatic check(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h want %h", name, act, exp);
  endtask

  task automatic m_reset();
    for (int i = 0; i < 2; i++) begin
      m_run[i]  = 0;
      m_dir[i]  = 0;
      m_idle[i] = 0;
      m_h[i]    = 1'b0;
      m_mv[i]   = '0;
    end
    m_sp = 0;
    m_p  = 1'b0;
    m_gr = 1'b0;
  endtask

  task automatic m_frame(input logic [4:0] b);
    int dir;
    int mag;
    bit u;
    bit d;
    bit fire;
    bit tog;
    for (int i = 0; i < 2; i++) begin
      u = b[2*i];
      d = b[2*i+1];
      dir = (u && !d) ? 1 : ((d && !u) ? -1 : 0);
      if (dir != 0 && dir == m_dir[i])
        m_run[i] = (m_run[i] < 15) ? m_run[i] + 1 : 15;
      else
        m_run[i] = 0;
      m_dir[i] = dir;
`ifdef PONG_INPUT_ACCEL_EN
      mag = (m_run[i] < 4) ? 2 : ((m_run[i] < 8) ? 4 : 8);
`else
      mag = 3;
`endif
      if (u || d) begin
        m_idle[i] = 0;
        m_h[i] = 1'b1;
      end else begin
        if (m_idle[i] < 750) m_idle[i]++;
        if (m_idle[i] >= 750) m_h[i] = 1'b0;
      end
      m_mv[i] = m_h[i] ? 9'(dir * mag) : 9'd0;
    end
    fire = 1'b0;
    tog = 1'b0;
    if (b[4]) begin
      m_sp++;
      fire = (m_sp == 100);
    end else begin
      tog = (m_sp >= 3 && m_sp < 100);
      m_sp = 0;
    end
    if (!m_h[0] && !m_h[1]) m_p = 1'b0;
    else if (fire) m_p = 1'b0;
    else if (tog) m_p = !m_p;
    m_gr = fire;
  endtask

  function automatic logic [21:0] m_vec();
    return {m_mv[0], m_mv[1], m_h[0], m_h[1], m_p, m_gr};
  endfunction

  function automatic logic [21:0] dut_vec();
    return {lbat_move, rbat_move, lbat_human, rbat_human, pause, game_reset};
  endfunction

  // one frame: settle buttons, one-cycle vsync low, sample after the tick
  task automatic do_frame(input logic [4:0] b);
    {btn_start, r_dn, r_up, l_dn, l_up} = b;
    repeat (3) @(posedge glb_clk);
    @(negedge glb_clk);
    vsync = 1'b0;
    @(posedge glb_clk);
    #1;
    o_out = dut_vec();
    @(negedge glb_clk);
    vsync = 1'b1;
    @(posedge glb_clk);
    #1;
    m_frame(b);
    check("model", 32'(o_out), 32'(m_vec()));
    check("gr_width", 32'(game_reset), 32'(m_gr & 1'b0));
  endtask

  task automatic add(input logic [4:0] b, input logic [8:0] lm,
                     input logic [8:0] rm, input logic lh, input logic rh,
                     input logic p);
    vec_t v;
    v.btn = b;
    v.exp = {lm, rm, lh, rh, p, 1'b0};
    tbl.push_back(v);
  endtask

  initial begin
    int k;
    int gr_cnt;
    int gr_at;
    bit prev_p;
    bit st_on;
    logic [4:0] rb;

    add(B_LUP, P2, 9'd0, 1, 0, 0);
    add(B_LUP, P2, 9'd0, 1, 0, 0);
    add(B_LUP, P2, 9'd0, 1, 0, 0);
    add(B_LUP, P2, 9'd0, 1, 0, 0);
    add(B_LUP, P4, 9'd0, 1, 0, 0);
    add(B_LUP, P4, 9'd0, 1, 0, 0);
    add(B_LUP, P4, 9'd0, 1, 0, 0);
    add(B_LUP, P4, 9'd0, 1, 0, 0);
    add(B_LUP, P8, 9'd0, 1, 0, 0);
    add(B_LUP, P8, 9'd0, 1, 0, 0);
    for (int i = 0; i < 4; i++) add(B_RDN, 9'd0, N2, 1, 1, 0);
    add(B_RDN, 9'd0, N4, 1, 1, 0);
    add(B_RUP, 9'd0, P2, 1, 1, 0);
    add(B_RUP | B_RDN, 9'd0, 9'd0, 1, 1, 0);
    add(B_ST, 9'd0, 9'd0, 1, 1, 0);
    add(B_ST, 9'd0, 9'd0, 1, 1, 0);
    add(B_NONE, 9'd0, 9'd0, 1, 1, 0);
    for (int i = 0; i < 5; i++) add(B_ST, 9'd0, 9'd0, 1, 1, 0);
    add(B_NONE, 9'd0, 9'd0, 1, 1, 1);
    for (int i = 0; i < 5; i++) add(B_ST, 9'd0, 9'd0, 1, 1, 1);
    add(B_NONE, 9'd0, 9'd0, 1, 1, 0);

    m_reset();
    repeat (3) @(posedge glb_clk);
    #1;
    check("reset_state", 32'(dut_vec()), 32'(0));
    @(negedge glb_clk);
    reset_n = 1'b1;

    foreach (tbl[i]) begin
      do_frame(tbl[i].btn);
      check($sformatf("vec%0d", i), 32'(o_out), 32'(tbl[i].exp));
    end

    // pause first, then long hold clears it with a single reset pulse
    for (int i = 0; i < 3; i++) do_frame(B_ST);
    do_frame(B_NONE);
    check("pause_set", 32'(pause), 32'(1));
    gr_cnt = 0;
    gr_at = 0;
    for (int i = 1; i <= 120; i++) begin
      do_frame(B_ST);
      if (o_out[0]) begin
        gr_cnt++;
        gr_at = i;
      end
    end
    check("gr_count", 32'(gr_cnt), 32'(1));
    check("gr_frame", 32'(gr_at), 32'(100));
    check("pause_after_gr", 32'(pause), 32'(0));
    do_frame(B_NONE);
    check("no_toggle_after_wait", 32'(pause), 32'(0));

    // static vsync freezes everything
    {btn_start, r_dn, r_up, l_dn, l_up} = 5'b11011;
    repeat (30) @(posedge glb_clk);
    #1;
    check("freeze", 32'(dut_vec()), 32'({m_mv[0], m_mv[1], m_h[0], m_h[1], m_p, 1'b0}));

    // both bats time out while paused
    do_frame(B_LDN | B_RDN);
    for (int i = 0; i < 3; i++) do_frame(B_ST);
    do_frame(B_NONE);
    check("pause_before_timeout", 32'(pause), 32'(1));
    k = 4;
    prev_p = pause;
    while (k < 800) begin
      prev_p = pause;
      k++;
      do_frame(B_NONE);
      if (!lbat_human) break;
    end
    check("timeout_frame", 32'(k), 32'(750));
    check("timeout_r_human", 32'(rbat_human), 32'(0));
    check("paused_prev", 32'(prev_p), 32'(1));
    check("attract_pause", 32'(pause), 32'(0));
    do_frame(B_NONE);
    check("lmove_after_timeout", 32'(lbat_move), 32'(0));

    // reset in the middle of a long start hold
    do_frame(B_LUP | B_RUP);
    gr_cnt = 0;
    for (int i = 0; i < 50; i++) begin
      do_frame(B_ST);
      if (o_out[0]) gr_cnt++;
    end
    @(negedge glb_clk);
    reset_n = 1'b0;
    @(posedge glb_clk);
    #1;
    check("midhold_reset", 32'(dut_vec()), 32'(0));
    @(posedge glb_clk);
    @(negedge glb_clk);
    reset_n = 1'b1;
    m_reset();
    for (int i = 0; i < 60; i++) begin
      do_frame(B_ST);
      if (o_out[0]) gr_cnt++;
    end
    check("no_gr_after_reset", 32'(gr_cnt), 32'(0));
    do_frame(B_NONE);

    // random frames against the model
    st_on = 1'b0;
    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(0, 7) == 0) st_on = !st_on;
      rb[0] = ($urandom_range(0, 2) == 0);
      rb[1] = ($urandom_range(0, 3) == 0);
      rb[2] = ($urandom_range(0, 2) == 0);
      rb[3] = ($urandom_range(0, 3) == 0);
      rb[4] = st_on;
      do_frame(rb);
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
